// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared state encoding and counter sizing for scan_ctrl
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - serial scan chain sequencer: load pattern, optional capture, unload old contents
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [CHAIN_LEN-1:0] i_in_data,
  input  logic                 i_in_capture,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [CHAIN_LEN-1:0] o_out_data,
  output logic                 o_se,
  output logic                 o_si,
  input  logic                 i_so,
  output logic                 o_cap_en
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CHAIN_LEN-1:0]  r_pattern;
  logic                  r_cap_flag;
  logic [CHAIN_LEN-1:0]  r_out_data;
  logic                  r_se;
  logic                  r_si;
  logic                  r_cap_en;
  logic                  r_out_valid;

  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_last;
  logic [CHAIN_LEN-1:0]  w_bit_mask;
  logic [CHAIN_LEN-1:0]  w_pat_shr;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = (r_cnt == LAST_CNT);
  // Shift-based indexing keeps the counter width independent of the chain index width.
  assign w_bit_mask = CHAIN_LEN'(1) << w_cnt_inc;
  assign w_pat_shr  = r_pattern >> w_cnt_inc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = r_cap_flag ? CAPTURE : DONE;
      CAPTURE: w_next = DONE;
      DONE:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_pattern   <= '0;
      r_cap_flag  <= 1'b0;
      r_out_data  <= '0;
      r_se        <= 1'b0;
      r_si        <= 1'b0;
      r_cap_en    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_se        <= (w_next == SHIFT);
      r_cap_en    <= (w_next == CAPTURE);
      r_out_valid <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_pattern  <= i_in_data;
            r_cap_flag <= i_in_capture;
            r_cnt      <= '0;
            r_out_data <= CHAIN_LEN'(i_so);
            r_si       <= i_in_data[0];
          end
        end
        SHIFT: begin
          // The final edge sees the new pattern's first bit on SO, so it is not sampled.
          if (!w_last) begin
            r_cnt      <= w_cnt_inc;
            r_out_data <= (r_out_data & ~w_bit_mask) | (i_so ? w_bit_mask : '0);
            r_si       <= w_pat_shr[0];
          end else begin
            r_si <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_se        = r_se;
  assign o_si        = r_si;
  assign o_cap_en    = r_cap_en;

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - directed scoreboard bench for scan_ctrl against a behavioural negedge chain
module tb_scan_ctrl;

  localparam int L = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [L-1:0] in_data;
  logic         in_capture;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] out_data;
  logic         se;
  logic         si;
  logic         so;
  logic         cap_en;

  logic [L-1:0] chain_q;
  logic         cap_invert;
  logic         preload_en;
  logic [L-1:0] preload_val;

  int total;
  int bad;
  logic [L-1:0] exp_q[$];
  logic [L-1:0] exp_chain;

  scan_ctrl #(.CHAIN_LEN(L)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_capture (in_capture),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_se         (se),
    .o_si         (si),
    .i_so         (so),
    .o_cap_en     (cap_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: head is bit L-1, tail (SO) is bit 0; D = ~Q when cap_invert, else D = Q.
  always @(negedge clk) begin
    if (preload_en)
      chain_q <= preload_val;
    else if (se)
      chain_q <= {si, chain_q[L-1:1]};
    else if (cap_en && cap_invert)
      chain_q <= ~chain_q;
  end
  assign so = chain_q[0];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [L-1:0] val);
    preload_val = val;
    preload_en  = 1'b1;
    @(negedge clk);
    #1;
    preload_en  = 1'b0;
  endtask

  task automatic run_txn(input logic [L-1:0] pat, input bit cap, input int hold,
                         input bit busy, input bit chk_data);
    int guard;
    int cyc;
    int se_cnt;
    int cap_cnt;
    int cap_at;
    logic [L-1:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check_eq("in_ready_before_load", in_ready, 1);
    in_valid   = 1'b1;
    in_data    = pat;
    in_capture = cap;
    step();
    in_valid   = 1'b0;
    in_capture = 1'b0;
    if (chk_data) exp_q.push_back(exp_chain);
    exp_chain = cap ? ~pat : pat;
    cyc = 0; se_cnt = 0; cap_cnt = 0; cap_at = -1;
    while (!out_valid && cyc < 40) begin
      if (se) se_cnt++;
      if (cap_en) begin
        cap_cnt++;
        cap_at = cyc;
      end
      if (busy && cyc == 3) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
      end
      step();
      in_valid = 1'b0;
      cyc++;
    end
    check_eq("latency", cyc, cap ? L + 1 : L);
    check_eq("se_cycles", se_cnt, L);
    check_eq("cap_cycles", cap_cnt, cap ? 1 : 0);
    check_eq("cap_position", cap_at, cap ? L : -1);
    if (chk_data) begin
      held = exp_q.pop_front();
      check_eq("out_data", out_data, held);
    end else begin
      held = out_data;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_out_data", out_data, held);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_se", se, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("post_hs_in_ready", in_ready, 1);
    check_eq("post_hs_out_valid", out_valid, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_capture = 1'b0; out_ready = 1'b0;
    cap_invert = 1'b0; preload_en = 1'b0; preload_val = '0; chain_q = '0;
    exp_chain = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_se", se, 0);
    check_eq("rst_cap_en", cap_en, 0);
    check_eq("rst_si", si, 0);
    check_eq("rst_out_data", out_data, 0);

    preload(8'h3C);
    exp_chain = 8'h3C;
    run_txn(8'hA5, 1'b0, 0, 1'b0, 1'b1);
    run_txn(8'h00, 1'b0, 5, 1'b0, 1'b1);

    cap_invert = 1'b1;
    run_txn(8'h0F, 1'b1, 0, 1'b0, 1'b1);
    run_txn(8'h12, 1'b0, 0, 1'b1, 1'b1);
    run_txn(8'h34, 1'b0, 0, 1'b0, 1'b1);

    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check_eq("midrst_se_before", se, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_se", se, 0);
    check_eq("midrst_cap_en", cap_en, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_txn(8'h55, 1'b0, 0, 1'b0, 1'b0);
    run_txn(8'hAA, 1'b1, 0, 1'b0, 1'b1);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

- Posedge-clocked sequencer that shares one serial scan chain of negative-edge flops between a host and the chain.
- Per transaction it serially loads a host-supplied pattern into the chain, optionally fires one capture cycle, and returns the chain's previous contents as a parallel word.
- Sits between the test/config host and the flop bank built from negedge DFF cells.

## Interface
- CHAIN_LEN, 16: number of flops in the chain, ≥1.
- CNT_W, $clog2(CHAIN_LEN+1): shift-counter width.
- CLK  in  1  single clock; controller logic on rising edge.
- R  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  host presents a pattern.
- IN_READY  out  1  controller accepts a pattern (high only in IDLE).
- IN_DATA  in  CHAIN_LEN  pattern; bit 0 shifted first, ends at chain tail.
- IN_CAPTURE  in  1  perform one capture cycle after the shift.
- OUT_VALID  out  1  unloaded word available.
- OUT_READY  in  1  host takes the word.
- OUT_DATA  out  CHAIN_LEN  previous chain contents; bit k = old tail-relative bit k.
- SE  out  1  scan enable to chain.
- SI  out  1  serial data into chain head.
- SO  in  1  serial data from chain tail.
- CAP_EN  out  1  functional-capture enable to chain.

## Operation
- States: IDLE, SHIFT, CAPTURE, DONE.
- **IDLE**
  - IN_READY=1.
  - On IN_VALID: latch IN_DATA into pattern register and IN_CAPTURE into a flag; clear counter; sample SO into OUT_DATA[0]; go to SHIFT.
- **SHIFT**
  - SE=1; SI=pattern[cnt]; the chain shifts on the falling edge inside the cycle.
  - At each rising edge with cnt<CHAIN_LEN-1: sample SO into OUT_DATA[cnt+1].
  - At the edge where cnt=CHAIN_LEN-1: go to CAPTURE if the flag is set, else DONE. SO is not sampled at this edge.
- **CAPTURE**
  - Exactly one cycle: SE=0, CAP_EN=1.
  - Then go to DONE.
- **DONE**
  - OUT_VALID=1; OUT_DATA held stable.
  - On OUT_READY: go to IDLE.
- SE, CAP_EN and OUT_VALID are registered state decodes; no combinational path from any input to them.
- IN_VALID outside IDLE is ignored. It is not queued.
- OUT_DATA is only meaningful while OUT_VALID=1; it is not cleared on handshake.
- CHAIN_LEN=1 case: SHIFT lasts one cycle and only the accept-edge sample is used.

## Timing
- Reset values: IN_READY=1 once R deasserts; OUT_VALID=0, SE=0, SI=0, CAP_EN=0, OUT_DATA=0; state IDLE, counter 0.
- R low at any time: return to IDLE asynchronously and force SE/CAP_EN low immediately. Chain contents are then undefined; the next transaction still returns whatever SO yields.
- Latency from the accepting edge to OUT_VALID rising: CHAIN_LEN cycles without capture, CHAIN_LEN+1 with capture.
- Throughput: one bubble cycle in IDLE after every DONE handshake.
- SI and SE launch on the rising edge and are sampled by the chain on the next falling edge. This half-cycle path is a timing constraint on the integration.
- SO is stable from the falling edge to the next rising edge, where the controller samples it.
- OUT_VALID/OUT_READY follows the standard valid/ready rule: OUT_VALID never drops without the handshake.

## Structure
- Package scan_ctrl_pkg holds the state enum (IDLE, SHIFT, CAPTURE, DONE) and the CNT_W function.
- Single module; no sub-module warranted.
- Benches use a separate behavioural chain model of CHAIN_LEN negedge flops with a scan mux. The model is test-only and is not synthesised with the block.

## Test plan
All scenarios use CHAIN_LEN=8 against the chain model.
- Reset: R low then high → IN_READY=1, OUT_VALID=SE=CAP_EN=SI=0 in the first post-reset cycle.
- Shift only: chain preloaded 0x3C, load 0xA5 with IN_CAPTURE=0 → SE high for exactly 8 cycles, CAP_EN never high, OUT_DATA=0x3C; next load 0x00 → OUT_DATA=0xA5.
- Capture: chain D = ~Q, load 0x0F with IN_CAPTURE=1 → CAP_EN high exactly one cycle after SE falls; next transaction returns 0xF0.
- Backpressure: OUT_READY low 5 cycles in DONE → OUT_VALID and OUT_DATA stable, IN_READY=0, SE=0; release → IDLE next edge, IN_READY=1.
- Busy input: IN_VALID pulsed with 0xFF during SHIFT → ignored, running transaction completes unchanged.
- Mid-shift reset: R low at cnt=3 → SE low without waiting for a clock edge, OUT_VALID=0; after release a fresh load of 0x55 completes normally.
